// File: rtl/package_finder.sv
// Header-hunting framer: strobes get_package after HEADER_REPEAT header words and masks the payload window.
// Define PKG_TRAILER_CHECK_EN to add the post-window trailer check and its error counter.
module package_finder #(
   parameter logic [15:0] HEADER_WORD    = 16'hAAAA,
   parameter int unsigned HEADER_REPEAT  = 2,
   parameter int unsigned PACKAGE_LENGTH = 1036,
   parameter logic [15:0] TRAILER_WORD   = 16'h5555
) (
   input  logic        clk,
   input  logic        live,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        get_package,
   output logic        in_package,
   output logic [15:0] pkg_count,
`ifdef PKG_TRAILER_CHECK_EN
   output logic [7:0]  trailer_err_count,
`endif
   output logic        trailer_err
);

   typedef enum logic [1:0] {StHunt, StPackage, StCheck} state_e;

   localparam logic [1:0]  MatchLast = 2'(HEADER_REPEAT - 1);
   localparam logic [11:0] WinLast   = 12'(PACKAGE_LENGTH);

   state_e      state_q, state_d;
   logic [1:0]  match_cnt_q, match_cnt_d;
   logic [11:0] win_cnt_q, win_cnt_d;
   logic [15:0] data_out_q;
   logic        get_package_q, get_package_d;
   logic        in_package_q, in_package_d;
   logic [15:0] pkg_count_q, pkg_count_d;
   logic        trailer_err_q, trailer_err_d;
   logic [7:0]  terr_cnt_q, terr_cnt_d;

   always_comb begin
      state_d       = state_q;
      match_cnt_d   = match_cnt_q;
      win_cnt_d     = win_cnt_q;
      get_package_d = 1'b0;
      in_package_d  = in_package_q;
      pkg_count_d   = pkg_count_q;
      trailer_err_d = 1'b0;
      case (state_q)
         StHunt: begin
            if (data_in == HEADER_WORD) begin
               if (match_cnt_q == MatchLast) begin
                  get_package_d = 1'b1;
                  pkg_count_d   = pkg_count_q + 16'd1;
                  match_cnt_d   = 2'd0;
                  win_cnt_d     = 12'd0;
                  in_package_d  = 1'b1;
                  state_d       = StPackage;
               end else begin
                  match_cnt_d = match_cnt_q + 2'd1;
               end
            end else begin
               match_cnt_d = 2'd0;
            end
         end
         StPackage: begin
            // Header words inside the window are payload.
            match_cnt_d = 2'd0;
            win_cnt_d   = win_cnt_q + 12'd1;
            if (win_cnt_q == WinLast) begin
               in_package_d = 1'b0;
`ifdef PKG_TRAILER_CHECK_EN
               state_d      = StCheck;
`else
               state_d      = StHunt;
`endif
            end
         end
`ifdef PKG_TRAILER_CHECK_EN
         StCheck: begin
            match_cnt_d   = 2'd0;
            trailer_err_d = (data_in != TRAILER_WORD);
            state_d       = StHunt;
         end
`endif
         default: state_d = StHunt;
      endcase
   end

   always_comb begin
      terr_cnt_d = terr_cnt_q;
      if (trailer_err_d && terr_cnt_q != 8'hFF) begin
         terr_cnt_d = terr_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge live) begin
      if (!live) begin
         state_q       <= StHunt;
         match_cnt_q   <= 2'd0;
         win_cnt_q     <= 12'd0;
         data_out_q    <= 16'd0;
         get_package_q <= 1'b0;
         in_package_q  <= 1'b0;
         pkg_count_q   <= 16'd0;
         trailer_err_q <= 1'b0;
         terr_cnt_q    <= 8'd0;
      end else begin
         state_q       <= state_d;
         match_cnt_q   <= match_cnt_d;
         win_cnt_q     <= win_cnt_d;
         data_out_q    <= data_in;
         get_package_q <= get_package_d;
         in_package_q  <= in_package_d;
         pkg_count_q   <= pkg_count_d;
         trailer_err_q <= trailer_err_d;
         terr_cnt_q    <= terr_cnt_d;
      end
   end

   assign data_out    = data_out_q;
   assign get_package = get_package_q;
   assign in_package  = in_package_q;
   assign pkg_count   = pkg_count_q;
   assign trailer_err = trailer_err_q;

`ifdef PKG_TRAILER_CHECK_EN
   assign trailer_err_count = terr_cnt_q;
`else
   logic unused_trailer;
   assign unused_trailer = ^{TRAILER_WORD, terr_cnt_q};
`endif

endmodule

// File: doc/package_finder.md
Name: package_finder

Overview:
- Upstream framing stage for the even/odd memory write controller.
- Scans the free-running 16-bit ADC/link word stream for a package header of HEADER_REPEAT consecutive HEADER_WORD words.
- On a match, issues a one-cycle get_package strobe, then masks header detection for the package payload window.
- Forwards the stream with one cycle of registered latency, so the write controller's first written word is the first payload word.

Parameters:
- HEADER_WORD, 16'hAAAA, header pattern word.
- HEADER_REPEAT, 2, number of consecutive HEADER_WORD words forming a header (legal range 1..4).
- PACKAGE_LENGTH, 1036, payload window length in words minus one. The window spans PACKAGE_LENGTH+1 words, matching the downstream writer. Legal range ≤ 4094.
- TRAILER_WORD, 16'h5555, expected word immediately after the window (used only with the optional feature).

Ports:
- clk  in  1  system clock
- live  in  1  asynchronous active-low reset; 0 = reset, 1 = run
- data_in  in  16  raw input word, valid every cycle
- data_out  out  16  data_in delayed one cycle (registered); drives write controller input_data
- get_package  out  1  one-cycle strobe, registered, aligned so the next data_out word is payload word 0
- in_package  out  1  high while the payload window is open
- pkg_count  out  16  packages found since reset; wraps at 16'hFFFF→0
- trailer_err  out  1  one-cycle strobe on trailer mismatch (only with the optional feature; otherwise tied 0)

Behaviour:
- Reset (live=0, asynchronous): state=HUNT; match_cnt=0; win_cnt=0; data_out=0; get_package=0; in_package=0; pkg_count=0; trailer_err=0. Reset takes effect immediately, including mid-package. The first edge after release is a normal HUNT cycle.
- data_out <= data_in on every edge, in every state. Latency is 1 cycle.
- HUNT state:
  - If data_in==HEADER_WORD: match_cnt <= match_cnt+1. Otherwise match_cnt <= 0.
  - When data_in==HEADER_WORD and match_cnt==HEADER_REPEAT-1: get_package <= 1, pkg_count <= pkg_count+1, match_cnt <= 0, win_cnt <= 0, state <= PACKAGE, in_package <= 1.
  - A run longer than HEADER_REPEAT yields only one strobe. Surplus header words fall inside the window as payload.
- PACKAGE state:
  - get_package <= 0.
  - Header detection is disabled: match_cnt is held at 0 and HEADER_WORD words are treated as payload.
  - win_cnt increments each edge. When win_cnt==PACKAGE_LENGTH: in_package <= 0 and state <= CHECK (feature on) or HUNT (feature off).
  - The window therefore covers exactly PACKAGE_LENGTH+1 data_in words, starting with the word after the last header word.
- CHECK state (feature on only): one cycle.
  - If data_in!=TRAILER_WORD: trailer_err <= 1.
  - Next state is HUNT.
  - The trailer word never counts toward a header match.
- Back-to-back packages: a header may begin on the first HUNT cycle after the window (or after CHECK). No dead cycles are required beyond that.
- get_package and trailer_err are never high for two consecutive cycles.
- match_cnt is 2 bits wide; win_cnt is 12 bits wide. Neither overflows in the legal parameter range.

Optional Feature:
- Macro PKG_TRAILER_CHECK_EN.
- Defined: the CHECK state exists, trailer_err is driven as specified, and an internal 8-bit saturating trailer-error counter is exposed on output trailer_err_count (reset 0, saturates at 8'hFF).
- Undefined: PACKAGE transitions straight to HUNT, trailer_err is tied 0, and trailer_err_count is absent.

Test Plan:
- Basic find: noise, then AAAA, AAAA, then payload words 0..1036 → get_package high exactly 1 cycle, on the edge after the second AAAA. data_out=0 on the following cycle. pkg_count=1. in_package low after 1037 window words.
- Broken header: AAAA, 1234, AAAA, 0000 → no get_package; pkg_count stays 0.
- Header inside payload: AAAA AAAA inserted at payload words 100–101 → no second strobe; pkg_count=1.
- Back-to-back: two packages with the second header starting immediately after the window (or trailer) → two strobes exactly 1037+HEADER_REPEAT (or +1 with CHECK) cycles apart; pkg_count=2.
- Reset mid-package: drop live at window word 500 → all outputs 0 asynchronously. A new header after release → get_package and pkg_count=1.
- Trailer (PKG_TRAILER_CHECK_EN): word after window = 5555 → trailer_err stays 0. Word = 0001 → trailer_err one-cycle pulse and trailer_err_count=1.
